// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two writeback sources, the arbiter and the
// register-file / hazard logic.
interface regfile_wb_arbiter_if #(
    parameter int PTRW = 2
);
    logic            a_valid;
    logic [4:0]      a_rd;
    logic [31:0]     a_data;
    logic            b_valid;
    logic            b_ready;
    logic [4:0]      b_rd;
    logic [31:0]     b_data;
    logic            wr_valid;
    logic [4:0]      wr_rd;
    logic [31:0]     wr_data;
    logic [4:0]      chk_rs1;
    logic [4:0]      chk_rs2;
    logic            chk_rs1_pend;
    logic            chk_rs2_pend;
    logic [PTRW:0]   fifo_count;

    // Sources, regfile and hazard logic side
    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data, chk_rs1, chk_rs2,
        input  b_ready, wr_valid, wr_rd, wr_data, chk_rs1_pend, chk_rs2_pend, fifo_count
    );

    // Arbiter side
    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, chk_rs1, chk_rs2,
        output b_ready, wr_valid, wr_rd, wr_data, chk_rs1_pend, chk_rs2_pend, fifo_count
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writebacks (A) always win;
// load-unit writebacks (B) are buffered in a small FIFO and drained in idle
// cycles. Older queued B writes to a register overwritten by A are squashed.
module regfile_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_wb_arbiter_if.slave bus
);
    logic [4:0]      ent_rd   [DEPTH];
    logic [31:0]     ent_data [DEPTH];
    logic [DEPTH-1:0] ent_vld;
    logic [PTRW-1:0] head;
    logic [PTRW-1:0] tail;
    logic [PTRW:0]   count;
    logic            b_fire;
    logic            enq;
    logic            pop;
    logic            a_squash;

    // Handshake and selection decode for this cycle
    always_comb begin
        b_fire   = bus.b_valid && bus.b_ready;
        enq      = b_fire && (bus.b_rd != '0);
        pop      = !bus.a_valid && (count != '0);
        a_squash = bus.a_valid && (bus.a_rd != '0);
    end

    assign bus.b_ready    = (count != (PTRW+1)'(DEPTH));
    assign bus.fifo_count = count;

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            if (enq && !pop)      count <= count + 1'b1;
            else if (pop && !enq) count <= count - 1'b1;
        end
    end

    // Entry valid bits: squash first so a same-cycle enqueue (younger) wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_vld <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (a_squash && ent_rd[i] == bus.a_rd) ent_vld[i] <= 1'b0;
                if (pop && head == PTRW'(i))            ent_vld[i] <= 1'b0;
                if (enq && tail == PTRW'(i))            ent_vld[i] <= 1'b1;
            end
        end
    end

    // Entry payload storage
    always_ff @(posedge clk) begin
        if (enq) begin
            ent_rd[tail]   <= bus.b_rd;
            ent_data[tail] <= bus.b_data;
        end
    end

    // Registered write port toward the register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wr_valid <= 1'b0;
            bus.wr_rd    <= '0;
            bus.wr_data  <= '0;
        end else if (bus.a_valid) begin
            bus.wr_valid <= 1'b1;
            bus.wr_rd    <= bus.a_rd;
            bus.wr_data  <= bus.a_data;
        end else if (pop) begin
            bus.wr_valid <= ent_vld[head];
            if (ent_vld[head]) begin
                bus.wr_rd   <= ent_rd[head];
                bus.wr_data <= ent_data[head];
            end
        end else begin
            bus.wr_valid <= 1'b0;
        end
    end

    // Pending flags: queued valid entries plus the write in the output stage
    always_comb begin
        logic hit1;
        logic hit2;
        hit1 = bus.wr_valid && (bus.wr_rd == bus.chk_rs1);
        hit2 = bus.wr_valid && (bus.wr_rd == bus.chk_rs2);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && ent_rd[i] == bus.chk_rs1) hit1 = 1'b1;
            if (ent_vld[i] && ent_rd[i] == bus.chk_rs2) hit2 = 1'b1;
        end
        bus.chk_rs1_pend = (bus.chk_rs1 != '0) && hit1;
        bus.chk_rs2_pend = (bus.chk_rs2 != '0) && hit2;
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic, compared against a queue-based reference model.
module tb_regfile_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int PTRW  = 2;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          vld;
    } ent_t;

    logic clk;
    logic rst_n;
    regfile_wb_arbiter_if #(.PTRW(PTRW)) bus ();

    regfile_wb_arbiter #(.DEPTH(DEPTH), .PTRW(PTRW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp;
    int n_bad;

    // Reference model state
    ent_t        mq[$];
    bit          m_wr_valid;
    logic [4:0]  m_wr_rd;
    logic [31:0] m_wr_data;

    // Register file fed from the DUT write port
    logic [31:0] rf [32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.wr_valid && bus.wr_rd != 5'd0) rf[bus.wr_rd] <= bus.wr_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_pend(input logic [4:0] q);
        bit hit;
        hit = m_wr_valid && (m_wr_rd == q);
        foreach (mq[i]) if (mq[i].vld && mq[i].rd == q) hit = 1'b1;
        return (q != 5'd0) && hit;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_wr_valid = 1'b0;
        m_wr_rd    = '0;
        m_wr_data  = '0;
    endtask

    // One clock cycle: drive inputs at the falling edge, check, then advance the model
    task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] adata,
                        input bit bv, input logic [4:0] brd, input logic [31:0] bdata,
                        input logic [4:0] c1, input logic [4:0] c2);
        bit   bfire;
        ent_t e;
        bus.a_valid = av;  bus.a_rd = ard;  bus.a_data = adata;
        bus.b_valid = bv;  bus.b_rd = brd;  bus.b_data = bdata;
        bus.chk_rs1 = c1;  bus.chk_rs2 = c2;
        #1;
        check_eq("b_ready",    32'(bus.b_ready),      32'(mq.size() != DEPTH));
        check_eq("fifo_count", 32'(bus.fifo_count),   32'(mq.size()));
        check_eq("rs1_pend",   32'(bus.chk_rs1_pend), 32'(model_pend(c1)));
        check_eq("rs2_pend",   32'(bus.chk_rs2_pend), 32'(model_pend(c2)));
        check_eq("wr_valid",   32'(bus.wr_valid),     32'(m_wr_valid));
        if (m_wr_valid) begin
            check_eq("wr_rd",   32'(bus.wr_rd), 32'(m_wr_rd));
            check_eq("wr_data", bus.wr_data,    m_wr_data);
        end
        @(posedge clk);
        bfire = bv && (mq.size() != DEPTH);
        if (av) begin
            m_wr_valid = 1'b1;
            m_wr_rd    = ard;
            m_wr_data  = adata;
            if (ard != 5'd0) foreach (mq[i]) if (mq[i].rd == ard) mq[i].vld = 1'b0;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_wr_valid = e.vld;
            if (e.vld) begin
                m_wr_rd   = e.rd;
                m_wr_data = e.data;
            end
        end else begin
            m_wr_valid = 1'b0;
        end
        if (bfire && brd != 5'd0) mq.push_back('{brd, bdata, 1'b1});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model_reset();
        rst_n = 1'b0;
        bus.a_valid = 0; bus.a_rd = 0; bus.a_data = 0;
        bus.b_valid = 0; bus.b_rd = 0; bus.b_data = 0;
        bus.chk_rs1 = 0; bus.chk_rs2 = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state, then a single pipeline write
        step(0, 0, 0, 0, 0, 0, 5'd5, 5'd0);
        step(1, 5'd5, 32'h11, 0, 0, 0, 5'd5, 5'd0);
        step(0, 0, 0, 0, 0, 0, 5'd5, 5'd1);
        step(0, 0, 0, 0, 0, 0, 5'd5, 5'd0);

        // B waits behind A, then drains in order
        step(1, 5'd1, 32'h1, 1, 5'd7, 32'hAA, 5'd7, 5'd8);
        step(1, 5'd2, 32'h2, 1, 5'd8, 32'hBB, 5'd7, 5'd8);
        step(1, 5'd3, 32'h3, 0, 0, 0, 5'd7, 5'd8);
        step(0, 0, 0, 0, 0, 0, 5'd7, 5'd8);
        idle(3);

        // Fill to DEPTH, blocked 5th transfer, accepted one cycle after the first pop
        for (int i = 0; i < DEPTH; i++)
            step(1, 5'd20, 32'(i), 1, 5'(10 + i), 32'h100 + 32'(i), 5'd10, 5'd13);
        step(1, 5'd21, 32'h5, 1, 5'd15, 32'h555, 5'd15, 5'd10);
        step(0, 0, 0, 1, 5'd15, 32'h555, 5'd15, 5'd11);
        step(0, 0, 0, 1, 5'd15, 32'h555, 5'd15, 5'd12);
        idle(6);

        // Squash: queued load to x9 is overwritten by a younger pipeline write
        step(1, 5'd3, 32'h33, 1, 5'd9, 32'hCC, 5'd9, 5'd3);
        step(1, 5'd9, 32'hDD, 0, 0, 0, 5'd9, 5'd3);
        step(0, 0, 0, 0, 0, 0, 5'd9, 5'd0);
        idle(3);
        check_eq("rf_x9", rf[9], 32'hDD);

        // Same-cycle B to the same rd as A is younger and survives
        step(1, 5'd6, 32'h66, 1, 5'd6, 32'h77, 5'd6, 5'd0);
        idle(3);
        check_eq("rf_x6", rf[6], 32'h77);

        // x0 B transfer completes the handshake without enqueueing
        step(0, 0, 0, 1, 5'd0, 32'hEE, 5'd0, 5'd0);
        idle(2);

        // Reset with three entries queued discards them
        for (int i = 0; i < 3; i++)
            step(1, 5'd4, 32'(i), 1, 5'(16 + i), 32'h200 + 32'(i), 5'd16, 5'd4);
        bus.a_valid = 0; bus.b_valid = 0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
        check_eq("rst_wr_valid",   32'(bus.wr_valid),   32'd0);
        check_eq("rst_b_ready",    32'(bus.b_ready),    32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            int unsigned a_pct;
            a_pct = (i % 400 < 200) ? 70 : 35;
            step($urandom_range(0, 99) < a_pct, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 99) < 60,    5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)),      5'($urandom_range(0, 7)));
        end
        idle(DEPTH + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (rd / data_des / data_valid) between two writeback sources.
  - Source A is the in-order execute pipeline: highest priority, no backpressure.
  - Source B is the load/long-latency unit: valid/ready handshake, buffered in a small FIFO.
- Drives a registered write port into the register file.
- Reports per-source-register "pending" flags so the hazard logic can stall reads of registers with writes still in flight.

Parameters:
- DEPTH, 4, B-side FIFO entries; power of two, minimum 2.
- PTRW, 2, pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  pipeline writeback request; always accepted.
- a_rd  in  5  pipeline destination register.
- a_data  in  32  pipeline writeback data.
- b_valid  in  1  LSU writeback request.
- b_ready  out  1  FIFO can accept; transfer occurs when b_valid && b_ready.
- b_rd  in  5  LSU destination register.
- b_data  in  32  LSU writeback data.
- wr_valid  out  1  to regfile data_valid.
- wr_rd  out  5  to regfile rd.
- wr_data  out  32  to regfile data_des.
- chk_rs1  in  5  register queried by hazard logic.
- chk_rs2  in  5  register queried by hazard logic.
- chk_rs1_pend  out  1  chk_rs1 has a write not yet committed.
- chk_rs2_pend  out  1  chk_rs2 has a write not yet committed.
- fifo_count  out  PTRW+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_valid=0, wr_rd=0, wr_data=0.
  - FIFO pointers, count and all entry valid bits cleared.
  - After reset: b_ready=1, fifo_count=0, pend flags 0.
  - Reset mid-operation discards all queued B writes with no regfile write.
- Write port: registered, one-cycle latency from selection to wr_*. The regfile commits on the following edge.
- Selection each cycle (evaluated in this order):
  - a_valid=1: wr_valid<=1, wr_rd<=a_rd, wr_data<=a_data. FIFO does not pop.
  - Else if FIFO non-empty: pop the head.
    - Head entry valid bit set: wr_valid<=1 with the head rd/data.
    - Head squashed: wr_valid<=0; the slot is freed in the same cycle.
  - Else: wr_valid<=0. wr_rd/wr_data hold their previous values.
- x0 handling:
  - a_valid with a_rd=0 is forwarded unchanged; the regfile ignores x0.
  - B transfer with b_rd=0 is accepted (handshake completes) but not enqueued; count is unchanged.
- FIFO:
  - b_ready = (fifo_count != DEPTH). Purely from count; no dependence on b_valid or a_valid.
  - Enqueue and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - Full: b_ready=0 until a pop occurs. A pop raises b_ready in the next cycle, not combinationally.
- Ordering and squash:
  - An A write is program-order younger than every B entry already in the FIFO.
  - On a_valid with a_rd!=0, every valid FIFO entry with rd==a_rd has its valid bit cleared in the same cycle. This prevents stale load data from overwriting the newer result.
  - A B transfer accepted in the same cycle as an A write to the same rd is treated as younger: it is enqueued valid and is not squashed.
  - A squashed entry still occupies its slot until popped. fifo_count includes it.
- Pending flags (combinational), for q in {rs1, rs2}:
  - chk_q_pend = (chk_q != 0) && (any valid FIFO entry with rd==chk_q, OR (wr_valid && wr_rd==chk_q)).
  - The current-cycle a_valid/b_valid inputs are not included.
- Starvation: B may wait indefinitely while a_valid is held high; no fairness counter. The pipeline's bubble rate guarantees drain.

Test Plan:
- Reset release → wr_valid=0, b_ready=1, fifo_count=0, chk_rs1_pend=0; assert rst_n low mid-stream with 3 entries queued → fifo_count=0 and no further wr_valid.
- a_valid=1 a_rd=5 a_data=0x11, no B traffic → next cycle wr_valid=1, wr_rd=5, wr_data=0x11; the cycle after, wr_valid=0.
- B enqueues rd=7 0xAA, rd=8 0xBB while a_valid held high 3 cycles → both wait, fifo_count=2, chk_rs1=7 gives pend=1; a_valid drops → wr outputs rd=7 then rd=8 on consecutive cycles, fifo_count returns to 0.
- DEPTH=4: fill with 4 B transfers while a_valid=1 → b_ready=0 and a 5th b_valid is not accepted; first pop → b_ready=1 on the next cycle, and the 5th transfer is accepted then.
- Queue B rd=9 0xCC, then a_valid a_rd=9 0xDD → wr_data=0xDD; the later pop of the squashed entry gives wr_valid=0; final regfile x9=0xDD.
- B transfer b_rd=0 → b_ready handshake completes, fifo_count stays 0, no write issued.
